// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : Circular byte queue that feeds a UART transmitter one frame at
//            a time through a start-pulse / done-pulse handshake.
// Revision : 1.0
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wrEnable,
    input  logic [7:0]       i_wrBits,
    input  logic             i_doneTx,
    output logic             o_enableTx,
    output logic [7:0]       o_bitsTx,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    output logic             o_busy,
    output logic             o_overflow
);

    localparam logic [1:0]       c_IDLE      = 2'd0;
    localparam logic [1:0]       c_SEND      = 2'd1;
    localparam logic [1:0]       c_WAIT_DONE = 2'd2;
    localparam logic [PTR_W:0]   c_FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_mem [DEPTH];
    logic [7:0]       r_bitsTx;
    logic             r_enableTx;
    logic             r_overflow;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_enableTxNext;

    assign w_full = (r_count == c_FULL_CNT);
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign w_push = i_wrEnable && !w_full;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:      if (r_count != '0) w_nextState = c_SEND;
            c_SEND:      w_nextState = c_WAIT_DONE;
            c_WAIT_DONE: if (i_doneTx) w_nextState = c_IDLE;
            default:     w_nextState = c_IDLE;
        endcase
    end

    // Output logic: the start pulse is registered from the SEND state
    always_comb begin
        w_pop          = 1'b0;
        w_enableTxNext = 1'b0;
        case (r_state)
            c_IDLE:  w_pop          = (r_count != '0);
            c_SEND:  w_enableTxNext = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wrBits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_bitsTx   <= 8'h00;
            r_enableTx <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_enableTx <= w_enableTxNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr  <= r_rdPtr + c_PTR_ONE;
                r_bitsTx <= r_mem[r_rdPtr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i_wrEnable && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_enableTx = r_enableTx;
    assign o_bitsTx   = r_bitsTx;
    assign o_full     = w_full;
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_busy     = (r_state != c_IDLE);
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Purpose  : Scoreboard bench for uart_tx_queue handshake, ordering and flags.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_queue;

    logic       clk;
    logic       rst_n;
    logic       i_wrEnable;
    logic [7:0] i_wrBits;
    logic       i_doneTx;
    logic       o_enableTx;
    logic [7:0] o_bitsTx;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_count;
    logic       o_busy;
    logic       o_overflow;

    int         nVectors;
    int         nMiscompares;
    logic [7:0] sb [$];
    logic [7:0] monExp;
    logic       monPrevEn;

    uart_tx_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wrEnable (i_wrEnable),
        .i_wrBits   (i_wrBits),
        .i_doneTx   (i_doneTx),
        .o_enableTx (o_enableTx),
        .o_bitsTx   (o_bitsTx),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter-side monitor: every start pulse must carry the oldest expected byte
    always @(negedge clk) begin
        if (o_enableTx === 1'b1) begin
            nVectors++;
            if (sb.size() == 0) begin
                nMiscompares++;
                $display("FAIL unexpected_tx: got byte %h, required no frame", o_bitsTx);
            end else begin
                monExp = sb.pop_front();
                if (o_bitsTx !== monExp) begin
                    nMiscompares++;
                    $display("FAIL tx_order: got %h, required %h", o_bitsTx, monExp);
                end
            end
            if (monPrevEn === 1'b1) begin
                nMiscompares++;
                $display("FAIL pulse_width: got enableTx high two cycles, required one");
            end
        end
        monPrevEn = o_enableTx;
    end

    task automatic push(input logic [7:0] b, input bit accept);
        i_wrEnable = 1'b1;
        i_wrBits   = b;
        if (accept) sb.push_back(b);
        @(posedge clk); #1;
        i_wrEnable = 1'b0;
    endtask

    task automatic doneTx();
        i_doneTx = 1'b1;
        @(posedge clk); #1;
        i_doneTx = 1'b0;
    endtask

    task automatic waitEnable(input string name);
        int n = 0;
        while (o_enableTx !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        nVectors++;
        if (o_enableTx !== 1'b1) begin
            nMiscompares++;
            $display("FAIL %s_timeout: got enableTx %b, required 1 within 20 cycles", name, o_enableTx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        nVectors++;
        if ({o_enableTx, o_bitsTx, o_overflow, o_empty, o_full, o_busy, o_count}
            !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            nMiscompares++;
            $display("FAIL reset_state: got en=%b bits=%h ovf=%b emp=%b full=%b busy=%b cnt=%0d, required 0 00 0 1 0 0 0",
                     o_enableTx, o_bitsTx, o_overflow, o_empty, o_full, o_busy, o_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        push(8'h31, 1'b1);
        nVectors++;
        if ({o_count, o_busy} !== {3'd1, 1'b0}) begin
            nMiscompares++;
            $display("FAIL single_push: got cnt=%0d busy=%b, required 1 0", o_count, o_busy);
        end
        @(posedge clk); #1;
        nVectors++;
        if ({o_bitsTx, o_empty, o_busy, o_enableTx} !== {8'h31, 1'b1, 1'b1, 1'b0}) begin
            nMiscompares++;
            $display("FAIL single_pop: got bits=%h emp=%b busy=%b en=%b, required 31 1 1 0",
                     o_bitsTx, o_empty, o_busy, o_enableTx);
        end
        @(posedge clk); #1;
        nVectors++;
        if (o_enableTx !== 1'b1) begin
            nMiscompares++;
            $display("FAIL single_latency: got enableTx %b, required 1", o_enableTx);
        end
        repeat (4) @(posedge clk); #1;
        nVectors++;
        if ({o_busy, o_enableTx, o_bitsTx} !== {1'b1, 1'b0, 8'h31}) begin
            nMiscompares++;
            $display("FAIL single_wait: got busy=%b en=%b bits=%h, required 1 0 31", o_busy, o_enableTx, o_bitsTx);
        end
        doneTx();
        nVectors++;
        if (o_busy !== 1'b0) begin
            nMiscompares++;
            $display("FAIL single_done: got busy %b, required 0", o_busy);
        end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 1'b1);
        nVectors++;
        if ({o_count, o_full, o_busy} !== {3'd3, 1'b0, 1'b1}) begin
            nMiscompares++;
            $display("FAIL fill_count: got cnt=%0d full=%b busy=%b, required 3 0 1", o_count, o_full, o_busy);
        end
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(posedge clk); #1;
            doneTx();
            waitEnable("fill");
        end
        nVectors++;
        if ({o_empty, o_overflow} !== {1'b1, 1'b0}) begin
            nMiscompares++;
            $display("FAIL fill_drained: got emp=%b ovf=%b, required 1 0", o_empty, o_overflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i), 1'b1);
        nVectors++;
        if ({o_count, o_full, o_busy} !== {3'd4, 1'b1, 1'b1}) begin
            nMiscompares++;
            $display("FAIL ovf_full: got cnt=%0d full=%b busy=%b, required 4 1 1", o_count, o_full, o_busy);
        end
        push(8'h58, 1'b0);
        nVectors++;
        if ({o_count, o_overflow} !== {3'd4, 1'b1}) begin
            nMiscompares++;
            $display("FAIL ovf_drop: got cnt=%0d ovf=%b, required 4 1", o_count, o_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            doneTx();
            waitEnable("ovf");
        end
        doneTx();
        nVectors++;
        if ({o_overflow, o_empty, o_busy} !== {1'b1, 1'b1, 1'b0}) begin
            nMiscompares++;
            $display("FAIL ovf_sticky: got ovf=%b emp=%b busy=%b, required 1 1 0", o_overflow, o_empty, o_busy);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) push(8'(k), 1'b1);
        for (int k = 4; k < 10; k++) begin
            doneTx();
            push(8'(k), 1'b1);
            waitEnable("wrap");
        end
        for (int k = 0; k < 3; k++) begin
            doneTx();
            waitEnable("wrap_drain");
        end
        doneTx();
        nVectors++;
        if ({o_empty, o_busy, o_bitsTx} !== {1'b1, 1'b0, 8'h09}) begin
            nMiscompares++;
            $display("FAIL wrap_end: got emp=%b busy=%b bits=%h, required 1 0 09", o_empty, o_busy, o_bitsTx);
        end
    endtask

    task automatic test_back_to_back();
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        doneTx();
        nVectors++;
        if ({o_busy, o_count} !== {1'b0, 3'd2}) begin
            nMiscompares++;
            $display("FAIL simul_idle: got busy=%b cnt=%0d, required 0 2", o_busy, o_count);
        end
        push(8'hA3, 1'b1);
        nVectors++;
        if ({o_busy, o_count, o_bitsTx} !== {1'b1, 3'd2, 8'hA1}) begin
            nMiscompares++;
            $display("FAIL simul_pushpop: got busy=%b cnt=%0d bits=%h, required 1 2 a1", o_busy, o_count, o_bitsTx);
        end
        doneTx();
        @(posedge clk); #1;
        nVectors++;
        if (o_busy !== 1'b1) begin
            nMiscompares++;
            $display("FAIL done_in_send: got busy %b, required 1", o_busy);
        end
        for (int i = 0; i < 2; i++) begin
            doneTx();
            waitEnable("b2b");
        end
        doneTx();
        doneTx();
        repeat (3) @(posedge clk); #1;
        nVectors++;
        if ({o_busy, o_count, o_enableTx} !== {1'b0, 3'd0, 1'b0}) begin
            nMiscompares++;
            $display("FAIL stray_done: got busy=%b cnt=%0d en=%b, required 0 0 0", o_busy, o_count, o_enableTx);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), (i == 0));
        nVectors++;
        if ({o_count, o_busy} !== {3'd3, 1'b1}) begin
            nMiscompares++;
            $display("FAIL mid_setup: got cnt=%0d busy=%b, required 3 1", o_count, o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        nVectors++;
        if ({o_enableTx, o_bitsTx, o_overflow, o_empty, o_full, o_busy, o_count}
            !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            nMiscompares++;
            $display("FAIL mid_reset: got en=%b bits=%h ovf=%b emp=%b full=%b busy=%b cnt=%0d, required 0 00 0 1 0 0 0",
                     o_enableTx, o_bitsTx, o_overflow, o_empty, o_full, o_busy, o_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        doneTx();
        repeat (5) @(posedge clk); #1;
        nVectors++;
        if ({o_busy, o_empty} !== {1'b0, 1'b1}) begin
            nMiscompares++;
            $display("FAIL mid_release: got busy=%b emp=%b, required 0 1", o_busy, o_empty);
        end
        push(8'hC5, 1'b1);
        waitEnable("mid_new");
        doneTx();
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        monPrevEn    = 1'b0;
        rst_n        = 1'b0;
        i_wrEnable   = 1'b0;
        i_wrBits     = 8'h00;
        i_doneTx     = 1'b0;
        test_reset();
        test_single();
        test_fill_order();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk); #1;
        nVectors++;
        if (sb.size() != 0) begin
            nMiscompares++;
            $display("FAIL scoreboard_left: got %0d bytes untransmitted, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of byte entries; SHALL be a power of two, 2..16.
REQ-002 Parameter: PTR_W, default 2, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port: i_wrEnable  in  1  push request; one byte is accepted per cycle in which it is high.
REQ-006 Port: i_wrBits  in  8  byte to push; sampled when i_wrEnable=1.
REQ-007 Port: i_doneTx  in  1  one-cycle pulse from the transmitter when the current frame completes.
REQ-008 Port: o_enableTx  out  1  one-cycle start pulse to the transmitter.
REQ-009 Port: o_bitsTx  out  8  byte presented to the transmitter.
REQ-010 Port: o_full  out  1  count==DEPTH.
REQ-011 Port: o_empty  out  1  count==0.
REQ-012 Port: o_count  out  PTR_W+1  stored entries, 0..DEPTH.
REQ-013 Port: o_busy  out  1  state!=IDLE.
REQ-014 Port: o_overflow  out  1  sticky flag; a push was dropped.

Function
REQ-015 Storage SHALL be a circular buffer: write pointer, read pointer and count; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 Push: when i_wrEnable=1 and o_full=0, the byte SHALL be written at the write pointer and the write pointer SHALL advance at that edge.
REQ-017 Push while full: the byte SHALL be discarded, pointers and count unchanged, and o_overflow SHALL be set; this applies even if a pop occurs in the same cycle.
REQ-018 Simultaneous push and pop with o_full=0: both SHALL occur; count unchanged.
REQ-019 The FSM SHALL have three states: IDLE, SEND, WAIT_DONE.
REQ-020 IDLE: if count!=0, the FSM SHALL load o_bitsTx with the head entry, advance the read pointer (pop), and go to SEND; otherwise it SHALL remain in IDLE.
REQ-021 SEND: o_enableTx SHALL be 1 for exactly this one cycle (registered); next state SHALL be WAIT_DONE.
REQ-022 WAIT_DONE: on i_doneTx=1, next state SHALL be IDLE; otherwise the FSM SHALL remain in WAIT_DONE, with no timeout.
REQ-023 i_doneTx SHALL be ignored in IDLE and SEND.
REQ-024 o_bitsTx SHALL hold its value from the pop edge until the next pop.
REQ-025 Latency: a push into an empty queue with the FSM in IDLE at edge E SHALL produce a pop at E+1 and o_enableTx=1 during the cycle after E+2; back-to-back frames SHALL be separated by one IDLE cycle after i_doneTx.
REQ-026 o_full, o_empty and o_count SHALL be derived from the registered count and reflect the state after the last edge.
REQ-027 Bytes SHALL leave the block in push order, with no loss except as in REQ-017.

Reset
REQ-028 While rst_n=0: state=IDLE, pointers=0, count=0, o_enableTx=0, o_bitsTx=8'h00, o_overflow=0, o_empty=1, o_full=0, o_busy=0.
REQ-029 Reset asserted mid-frame SHALL discard all stored bytes and the pending handshake.
REQ-030 After reset release, the first i_doneTx SHALL be ignored unless the FSM is in WAIT_DONE.

Verification
REQ-031 Single byte: push 8'h31 at edge E -> o_bitsTx=8'h31 from E+1; o_enableTx pulse of one cycle at E+2; o_busy=1 until i_doneTx; o_empty=1 after E+1.
REQ-032 Fill and order: push 8'h41, 42, 43, 44 in consecutive cycles while withholding i_doneTx -> after the first pop, count=3 and o_full=0; pulse i_doneTx three times -> o_bitsTx sequence 41, 42, 43, 44, each with one o_enableTx pulse.
REQ-033 Overflow: with the FSM in WAIT_DONE and count=4, push 8'h58 -> dropped, o_overflow=1 and stays 1; 8'h58 is never transmitted.
REQ-034 Wrap-around: push and drain 10 bytes 8'h00..8'h09 -> output order 00..09 exactly; pointers wrap with no gap.
REQ-035 Simultaneous events: push in the same cycle as an IDLE pop with count=2 -> count stays 2; stray i_doneTx in IDLE -> no state change.
REQ-036 Reset mid-operation: assert rst_n=0 in WAIT_DONE with count=3 -> all outputs take REQ-028 values immediately; no o_enableTx after release until a new push.
